// File: rtl/lt24_blit_pkg.sv
// Shared types and sizes for the background-to-picture blitter.
package lt24_blit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

    localparam int BG_AW   = 13;
    localparam int PIC_AW  = 12;
    localparam int PIX_W   = 16;
    localparam int MAX_DIM = 64;
    localparam int DIM_W   = $clog2(MAX_DIM) + 1;

endpackage

// File: rtl/blit_delay_line.sv
// Shift register that carries {valid, destination address} alongside each
// background read, so the write lands exactly when the read data returns.
module blit_delay_line #(
    parameter int READ_LATENCY = 1,
    parameter int AW           = 12
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_vld,
    input  logic [AW-1:0] i_addr,
    output logic          o_vld,
    output logic [AW-1:0] o_addr
);

    logic [READ_LATENCY-1:0] r_vld;
    logic [AW-1:0]           r_addr [READ_LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[READ_LATENCY-1:0], i_vld} >> 0;
        end
    end

    // Address is qualified by the valid bit, so it needs no reset.
    always_ff @(posedge i_clk) begin
        r_addr[0] <= i_addr;
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_addr[i] <= r_addr[i-1];
        end
    end

    assign o_vld  = r_vld[READ_LATENCY-1];
    assign o_addr = r_addr[READ_LATENCY-1];

endmodule

// File: rtl/bg_pic_blitter.sv
// Rectangle copy engine: reads background memory, writes picture memory at
// one pixel per clock, with optional transparent-colour skip.
module bg_pic_blitter
    import lt24_blit_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int PIC_STRIDE   = 64
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic [BG_AW-1:0]  src_base,
    input  logic [BG_AW-1:0]  src_stride,
    input  logic [PIC_AW-1:0] dst_base,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic              key_en,
    input  logic [PIX_W-1:0]  key_value,
    output logic              busy,
    output logic              done,
    output logic [BG_AW-1:0]  bg_address,
    output logic              bg_chipselect,
    output logic              bg_clken,
    output logic              bg_write,
    output logic [PIX_W-1:0]  bg_writedata,
    output logic [1:0]        bg_byteenable,
    input  logic [PIX_W-1:0]  bg_readdata,
    output logic [PIC_AW-1:0] pic_address,
    output logic              pic_chipselect,
    output logic              pic_clken,
    output logic              pic_write,
    output logic [PIX_W-1:0]  pic_writedata,
    output logic [1:0]        pic_byteenable
);

    localparam logic [PIC_AW-1:0] PIC_STEP   = PIC_AW'(PIC_STRIDE);
    localparam logic [1:0]        DRAIN_LAST = 2'(READ_LATENCY - 1);

    blit_state_t       r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_vld;
    logic [BG_AW-1:0]  r_bg_address;
    logic [BG_AW-1:0]  r_src_row;
    logic [PIC_AW-1:0] r_dst_addr;
    logic [PIC_AW-1:0] r_dst_row;
    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_row;
    logic [1:0]        r_drain;

    logic [DIM_W-1:0]  r_width;
    logic [DIM_W-1:0]  r_height;
    logic [BG_AW-1:0]  r_src_stride;
    logic              r_key_en;
    logic [PIX_W-1:0]  r_key_value;

    logic              w_last_col;
    logic              w_last_pix;
    logic              w_wr_vld;
    logic [PIC_AW-1:0] w_wr_addr;
    logic              w_keyed;
    logic              w_pic_we;

    assign w_last_col = (r_col == r_width - DIM_W'(1));
    assign w_last_pix = w_last_col && (r_row == r_height - DIM_W'(1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_bg_address <= '0;
            r_src_row    <= '0;
            r_dst_addr   <= '0;
            r_dst_row    <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_drain      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (width != '0 && height != '0) begin
                            r_state      <= ST_RUN;
                            r_rd_vld     <= 1'b1;
                            r_bg_address <= src_base;
                            r_src_row    <= src_base;
                            r_dst_addr   <= dst_base;
                            r_dst_row    <= dst_base;
                            r_col        <= '0;
                            r_row        <= '0;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_last_pix) begin
                        r_state      <= ST_DRAIN;
                        r_rd_vld     <= 1'b0;
                        r_bg_address <= '0;
                        r_drain      <= DRAIN_LAST;
                    end else if (w_last_col) begin
                        // Row wrap: both bases step by their own pitch.
                        r_col        <= '0;
                        r_row        <= r_row + DIM_W'(1);
                        r_src_row    <= r_src_row + r_src_stride;
                        r_bg_address <= r_src_row + r_src_stride;
                        r_dst_row    <= r_dst_row + PIC_STEP;
                        r_dst_addr   <= r_dst_row + PIC_STEP;
                    end else begin
                        r_col        <= r_col + DIM_W'(1);
                        r_bg_address <= r_bg_address + BG_AW'(1);
                        r_dst_addr   <= r_dst_addr + PIC_AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == 2'd0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 2'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request parameters are captured once so mid-copy input changes are ignored.
    always_ff @(posedge clk_clk) begin
        if (r_state == ST_IDLE && start) begin
            r_width      <= width;
            r_height     <= height;
            r_src_stride <= src_stride;
            r_key_en     <= key_en;
            r_key_value  <= key_value;
        end
    end

    blit_delay_line #(
        .READ_LATENCY (READ_LATENCY),
        .AW           (PIC_AW)
    ) u_delay (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_vld   (r_rd_vld),
        .i_addr  (r_dst_addr),
        .o_vld   (w_wr_vld),
        .o_addr  (w_wr_addr)
    );

    assign w_keyed  = r_key_en && (bg_readdata == r_key_value);
    assign w_pic_we = w_wr_vld && !w_keyed;

    assign busy           = r_busy;
    assign done           = r_done;
    assign bg_address     = r_bg_address;
    assign bg_chipselect  = r_rd_vld;
    assign bg_clken       = r_rd_vld;
    assign bg_write       = 1'b0;
    assign bg_writedata   = '0;
    assign bg_byteenable  = 2'b11;
    assign pic_address    = w_pic_we ? w_wr_addr : '0;
    assign pic_chipselect = w_pic_we;
    assign pic_clken      = w_pic_we;
    assign pic_write      = w_pic_we;
    assign pic_writedata  = w_pic_we ? bg_readdata : '0;
    assign pic_byteenable = 2'b11;

endmodule
